display_word_scanner: RTL
=========================

# display_word_scanner

Sequential fetch stage feeding the board's eight seven-segment hex decoders. It walks a window of words in the CPU's pixel memory through a synchronous read port and presents each word on a 32-bit display bus (nibble 0 → HEX0 … nibble 7 → HEX7) for a fixed dwell time. It honours the system `halt` line and accepts a debounced single-step pulse for manual inspection.

## Interface
- `NUM_WORDS`, 16, words in the scanned window; ≥ 1.
- `ADDR_W`, 8, memory address width; `2**ADDR_W` ≥ `BASE_ADDR + NUM_WORDS`.
- `BASE_ADDR`, 0, first word address of the window.
- `DWELL_CYCLES`, 50_000_000, clock cycles each word is held; ≥ 1.

Ports:
- `clk`  in  1  single system clock; all logic on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `halt`  in  1  level; freezes automatic scanning.
- `step`  in  1  one-cycle pulse, already debounced; advance to the next word now.
- `mem_rd_en`  out  1  read strobe to pixel memory, one cycle per fetch.
- `mem_addr`  out  ADDR_W  read address, valid while `mem_rd_en` = 1.
- `mem_rdata`  in  32  read data, valid exactly one cycle after `mem_rd_en`.
- `display_word`  out  32  word currently shown; registered.
- `word_valid`  out  1  high once the first word has been captured.
- `word_index`  out  `$clog2(NUM_WORDS)` (min 1)  index of the displayed word within the window.

## Operation
- States: FETCH, WAIT_DATA, HOLD.
- FETCH: drive `mem_rd_en` = 1 and `mem_addr` = `BASE_ADDR + idx` for one cycle, then go to WAIT_DATA. No conditions apply.
- WAIT_DATA: on the next edge, capture `mem_rdata` into `display_word`, set `word_index` = `idx`, set `word_valid` = 1, clear the dwell counter, then go to HOLD.
- HOLD: the dwell counter increments each cycle while `halt` = 0.
  - When the counter reaches `DWELL_CYCLES-1` with `halt` = 0, or when `step` = 1, set `idx` ← (`idx` = `NUM_WORDS-1`) ? 0 : `idx`+1 and go to FETCH.
- `halt` = 1: the dwell counter holds its value and `display_word` is unchanged.
  - An in-flight FETCH/WAIT_DATA always completes; `halt` never drops a returned word.
- `step` in HOLD advances regardless of `halt`, so a halted CPU can be inspected word by word.
- `step` in FETCH or WAIT_DATA is ignored and not queued.
- `step` and dwell expiry in the same cycle produce a single advance.
- `NUM_WORDS` = 1: each advance re-fetches address `BASE_ADDR`, which refreshes a changed memory word.
- `mem_rd_en` is never high in two consecutive cycles.

## Timing
- Reset values: `mem_rd_en` 0, `mem_addr` 0, `display_word` 0, `word_valid` 0, `word_index` 0; internal `idx` 0, state FETCH, dwell counter 0.
- Reset has priority over everything, including mid-fetch.
  - A `mem_rdata` returning in the cycle after reset is discarded.
- First fetch: `mem_rd_en` = 1 in the first cycle after `reset` falls (cycle 0). `display_word` updates at the end of cycle 1 and is visible from cycle 2.
- Steady period per word with `halt` = 0 and no `step`: `DWELL_CYCLES + 2` cycles.
- `step` seen in HOLD in cycle n: `mem_rd_en` in cycle n+1, new `display_word` visible from cycle n+3.
- Dwell counter width is `$clog2(DWELL_CYCLES)` (min 1). It never wraps; it saturates at the compare value.

## Test plan
- Reset release, `NUM_WORDS`=4, `DWELL_CYCLES`=4, memory[i] = 32'h1111_1111·(i+1):
  - read strobe at cycle 0 with addr 0; `display_word`=32'h1111_1111 and `word_valid`=1 from cycle 2.
  - next strobe at cycle 6 with addr 1.
- Wrap-around, same setup: after word 3 (32'h4444_4444), the next strobe uses addr 0 and `word_index` returns to 0. Over 24 cycles, exactly 4 strobes occur, 6 cycles apart.
- `halt`=1 for 20 cycles entering HOLD at dwell count 2:
  - no strobe and `display_word` stable throughout.
  - after release, the advance occurs 2 cycles later (counter resumed, not restarted).
- `step` pulse while `halt`=1 in HOLD: one strobe the next cycle and the new word visible 3 cycles after `step`. A second `step` during WAIT_DATA produces no extra strobe.
- `step` coinciding with dwell expiry: exactly one advance (index +1, not +2).
- `reset` asserted in WAIT_DATA while memory returns 32'hDEAD_BEEF: `display_word` stays 0, `word_valid` 0, and the fetch restarts at addr 0 after release.

Source files
------------

// File: rtl/display_word_scanner_if.sv
// Synchronous read port between the display scanner (master) and pixel memory (slave).
interface display_word_scanner_if #(
  parameter int unsigned ADDR_W = 8
);
  logic              mem_rd_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_rdata;

  modport master (output mem_rd_en, output mem_addr, input  mem_rdata);
  modport slave  (input  mem_rd_en, input  mem_addr, output mem_rdata);
endinterface

// File: rtl/display_word_scanner.sv
// Walks a window of pixel-memory words and holds each on the 32-bit hex display bus
// for a fixed dwell, with halt freeze and manual single-step.
module display_word_scanner #(
  parameter int unsigned NUM_WORDS    = 16,
  parameter int unsigned ADDR_W       = 8,
  parameter int unsigned BASE_ADDR    = 0,
  parameter int unsigned DWELL_CYCLES = 50_000_000,
  localparam int unsigned IW = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          halt,
  input  logic                          step,
  display_word_scanner_if.master        mem,
  output logic [31:0]                   display_word,
  output logic                          word_valid,
  output logic [IW-1:0]                 word_index
);

  localparam int unsigned CW = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
  localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL_CYCLES - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_WORDS - 1);

  typedef enum logic [1:0] {
    FETCH,
    WAIT_DATA,
    HOLD
  } state_t;

  state_t        state;
  state_t        state_next;
  logic [IW-1:0] idx;
  logic [CW-1:0] dwell_cnt;
  logic          rd_en;
  logic          advance;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= FETCH;
    end else begin
      state <= state_next;
    end
  end

  // step and dwell expiry share one advance, so a coincidence moves by a single word.
  always_comb begin
    state_next = state;
    rd_en      = 1'b0;
    advance    = 1'b0;
    case (state)
      FETCH: begin
        rd_en      = 1'b1;
        state_next = WAIT_DATA;
      end
      WAIT_DATA: begin
        state_next = HOLD;
      end
      HOLD: begin
        if (step || (!halt && (dwell_cnt == DWELL_LAST))) begin
          advance    = 1'b1;
          state_next = FETCH;
        end
      end
      default: begin
        state_next = FETCH;
      end
    endcase
  end

  // The FETCH strobe is combinational so it appears in the first cycle after reset;
  // gating with reset keeps the bus quiet while reset is held.
  assign mem.mem_rd_en = rd_en && !reset;
  assign mem.mem_addr  = mem.mem_rd_en ? (ADDR_W'(BASE_ADDR) + ADDR_W'(idx)) : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      idx          <= '0;
      dwell_cnt    <= '0;
      display_word <= '0;
      word_valid   <= 1'b0;
      word_index   <= '0;
    end else begin
      case (state)
        WAIT_DATA: begin
          display_word <= mem.mem_rdata;
          word_index   <= idx;
          word_valid   <= 1'b1;
          dwell_cnt    <= '0;
        end
        HOLD: begin
          if (advance) begin
            idx <= (idx == IDX_LAST) ? '0 : idx + IW'(1);
          end else if (!halt && (dwell_cnt != DWELL_LAST)) begin
            dwell_cnt <= dwell_cnt + CW'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule
